// File: rtl/serdes_framed.sv
// serdes_framed: DATA_W-bit framed serializer plus self-aligning deserializer.
// Line frame = SYNC_WORD, flag bit, then a payload word when the flag is 1.
// The receiver hunts for SYNC, locks after LOCK_CNT good frames, flywheels
// through up to LOSS_CNT-1 consecutive bad markers and delivers payload words.
module serdes_framed #(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] SYNC_WORD = 8'h81,
   parameter bit                MSB_FIRST = 1'b1,
   parameter int                LOCK_CNT  = 2,
   parameter int                LOSS_CNT  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              ser_out,
   input  logic              ser_in,
   input  logic              loopback,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_locked,
   output logic              sync_err
);

   localparam int              CW        = $clog2(DATA_W);
   localparam logic [CW-1:0]   BIT_LAST  = CW'(DATA_W - 1);
   localparam int              GW        = $clog2(LOCK_CNT + 1);
   localparam logic [GW-1:0]   GOOD_MAX  = GW'(LOCK_CNT);
   localparam int              MW        = $clog2(LOSS_CNT + 1);
   localparam logic [MW-1:0]   MISS_MAX  = MW'(LOSS_CNT);

   typedef enum logic [1:0] {T_SYNC = 2'd0, T_FLAG = 2'd1, T_DATA = 2'd2} tx_state_t;
   typedef enum logic [1:0] {R_HUNT = 2'd0, R_FLAG = 2'd1, R_DATA = 2'd2, R_CHECK = 2'd3} rx_state_t;

   // Line bit number idx of a word, honouring the configured bit order.
   function automatic logic line_bit(input logic [DATA_W-1:0] word, input logic [CW-1:0] idx);
      logic b;
      if (MSB_FIRST) b = word[BIT_LAST - idx];
      else           b = word[idx];
      return b;
   endfunction

   tx_state_t         tx_state_q, tx_state_d;
   logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic              hold_full_q, hold_full_d;
   logic              tx_ready_q, tx_ready_d;
   logic              ser_out_q, ser_out_d;

   rx_state_t         rx_state_q, rx_state_d;
   logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [GW-1:0]     good_q, good_d;
   logic [MW-1:0]     miss_q, miss_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_locked_q, rx_locked_d;
   logic              sync_err_q, sync_err_d;

   logic              accept_s;
   logic              rx_bit_s;
   logic              sync_hit_s;

   // Next-state logic for the transmit framer and the receive aligner.
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_shift_d  = tx_shift_q;
      hold_data_d = hold_data_q;
      hold_full_d = hold_full_q;
      ser_out_d   = ser_out_q;
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      good_d      = good_q;
      miss_d      = miss_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      rx_locked_d = rx_locked_q;
      sync_err_d  = 1'b0;

      // Holding register: tx_data is only captured on a handshake.
      accept_s = tx_valid && tx_ready_q;
      if (accept_s) begin
         hold_full_d = 1'b1;
         hold_data_d = tx_data;
      end else begin
         hold_data_d = hold_data_q;
      end

      case (tx_state_q)
         T_SYNC: begin
            ser_out_d = line_bit(SYNC_WORD, tx_cnt_q);
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = T_FLAG;
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         T_FLAG: begin
            ser_out_d = hold_full_q;
            tx_cnt_d  = '0;
            if (hold_full_q) begin
               tx_shift_d  = hold_data_q;
               hold_full_d = 1'b0;
               tx_state_d  = T_DATA;
            end else begin
               tx_state_d = T_SYNC;
            end
         end
         T_DATA: begin
            ser_out_d = line_bit(tx_shift_q, tx_cnt_q);
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = T_SYNC;
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         default: begin
            ser_out_d  = 1'b0;
            tx_cnt_d   = '0;
            tx_state_d = T_SYNC;
         end
      endcase
      tx_ready_d = !hold_full_d;

      // Receive shift register always holds the last DATA_W line bits as a word.
      rx_bit_s = loopback ? ser_out_q : ser_in;
      if (MSB_FIRST) sr_d = {sr_q[DATA_W-2:0], rx_bit_s};
      else           sr_d = {rx_bit_s, sr_q[DATA_W-1:1]};
      sync_hit_s = (sr_d == SYNC_WORD);

      case (rx_state_q)
         R_HUNT: begin
            rx_cnt_d = '0;
            if (sync_hit_s) begin
               good_d     = GW'(1);
               rx_state_d = R_FLAG;
            end else begin
               rx_state_d = R_HUNT;
            end
         end
         R_FLAG: begin
            rx_cnt_d   = '0;
            rx_state_d = rx_bit_s ? R_DATA : R_CHECK;
         end
         R_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_data_d  = sr_d;
               rx_valid_d = rx_locked_q;
               rx_state_d = R_CHECK;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         R_CHECK: begin
            if (rx_cnt_q != BIT_LAST) begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end else if (sync_hit_s) begin
               rx_cnt_d   = '0;
               good_d     = (good_q >= GOOD_MAX) ? GOOD_MAX : good_q + GW'(1);
               miss_d     = '0;
               rx_locked_d = rx_locked_q || (good_d >= GOOD_MAX);
               rx_state_d = R_FLAG;
            end else if (!rx_locked_q) begin
               rx_cnt_d   = '0;
               good_d     = '0;
               rx_state_d = R_HUNT;
            end else begin
               // Locked: report the bad marker, drop lock only after LOSS_CNT in a row.
               rx_cnt_d   = '0;
               sync_err_d = 1'b1;
               if (miss_q + MW'(1) >= MISS_MAX) begin
                  rx_locked_d = 1'b0;
                  good_d      = '0;
                  miss_d      = '0;
                  rx_state_d  = R_HUNT;
               end else begin
                  miss_d     = miss_q + MW'(1);
                  rx_state_d = R_FLAG;
               end
            end
         end
         default: begin
            rx_cnt_d   = '0;
            rx_state_d = R_HUNT;
         end
      endcase
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q  <= T_SYNC;
         tx_cnt_q    <= '0;
         tx_shift_q  <= '0;
         hold_data_q <= '0;
         hold_full_q <= 1'b0;
         tx_ready_q  <= 1'b0;
         ser_out_q   <= 1'b0;
         rx_state_q  <= R_HUNT;
         rx_cnt_q    <= '0;
         sr_q        <= '0;
         good_q      <= '0;
         miss_q      <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         rx_locked_q <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_shift_q  <= tx_shift_d;
         hold_data_q <= hold_data_d;
         hold_full_q <= hold_full_d;
         tx_ready_q  <= tx_ready_d;
         ser_out_q   <= ser_out_d;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         sr_q        <= sr_d;
         good_q      <= good_d;
         miss_q      <= miss_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_locked_q <= rx_locked_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign tx_ready  = tx_ready_q;
   assign ser_out   = ser_out_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign rx_locked = rx_locked_q;
   assign sync_err  = sync_err_q;

endmodule
